// File: rtl/seven_seg_serial_mux.sv
// seven_seg_serial_mux: double-dabble BCD conversion and serial scan of a multi-digit 7-seg board.
// Optional macro SEVSEG_BLANK_EN enables leading-zero blanking.
module seven_seg_serial_mux #(
  parameter int BIN_W   = 16,
  parameter int DIGITS  = 4,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] bin,
  input  logic             load,
  output logic             conv_busy,
  output logic             overflow,
  output logic             seg_data,
  output logic             seg_clk,
  output logic             seg_latch
);
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction
  localparam logic [63:0] LIMIT = pow10(DIGITS);
  localparam int DW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  localparam int VW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [7:0] SEG [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t state;
  logic [BIN_W-1:0] sreg;
  logic [DW-1:0] bcd, bcd_adj, disp_bcd;
  logic disp_ovf;
  logic [CW-1:0] steps;
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      bcd_adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      conv_busy <= 1'b0;
      overflow  <= 1'b0;
      sreg      <= '0;
      bcd       <= '0;
      disp_bcd  <= '0;
      disp_ovf  <= 1'b0;
      steps     <= '0;
    end else begin
      case (state)
        IDLE: if (load) begin
          sreg      <= bin;
          overflow  <= 64'(bin) >= LIMIT;
          bcd       <= '0;
          steps     <= '0;
          conv_busy <= 1'b1;
          state     <= CONV;
        end
        CONV: begin
          bcd   <= {bcd_adj[DW-2:0], sreg[BIN_W-1]};
          sreg  <= sreg << 1;
          steps <= steps + 1'b1;
          if (steps == CW'(BIN_W - 1)) state <= DONE;
        end
        DONE: begin
          disp_bcd  <= bcd;
          disp_ovf  <= overflow;
          conv_busy <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  logic [VW-1:0] div;
  logic [5:0] half;
  logic [4:0] slot;
  logic [2:0] dig;
  logic [15:0] frame, word;
  logic [3:0] nib;
  logic blank, frame_start;
  assign slot = half[5:1];
  assign frame_start = div == '0 && half == '0;
  assign nib = 4'(disp_bcd >> {dig, 2'b00});
`ifdef SEVSEG_BLANK_EN
  assign blank = !disp_ovf && dig != 3'd0 && (disp_bcd >> {dig, 2'b00}) == '0;
`else
  assign blank = 1'b0;
`endif
  assign word = {~(8'd1 << dig), disp_ovf ? 8'hBF : blank ? 8'hFF : SEG[nib]};
  // Outputs are registered from the pre-edge position, so the stream lags the counters by one clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div       <= '0;
      half      <= '0;
      dig       <= '0;
      frame     <= '0;
      seg_data  <= 1'b0;
      seg_clk   <= 1'b0;
      seg_latch <= 1'b0;
    end else begin
      div <= div == VW'(CLK_DIV - 1) ? '0 : div + 1'b1;
      if (div == VW'(CLK_DIV - 1)) begin
        half <= half == 6'd33 ? '0 : half + 1'b1;
        if (half == 6'd33) dig <= dig == 3'(DIGITS - 1) ? '0 : dig + 1'b1;
      end
      if (frame_start) frame <= word;
      seg_data  <= frame_start ? word[15] : slot < 5'd16 && frame[~slot[3:0]];
      seg_clk   <= slot < 5'd16 && half[0];
      seg_latch <= slot == 5'd16;
    end
  end
endmodule

// File: tb/tb_seven_seg_serial_mux.sv
// tb_seven_seg_serial_mux: randomized loads checked cycle-by-cycle against an arithmetic display model.
module tb_seven_seg_serial_mux;
  localparam int BW = 16, ND = 4, CD = 2, FL = 34 * CD;
  localparam logic [7:0] SEGS [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  logic clk = 1'b0, rst, load;
  logic [BW-1:0] bin;
  logic conv_busy, overflow, seg_data, seg_clk, seg_latch;
  int checks = 0, errors = 0;
  int n, cap_edge, last_dig, last_slot;
  bit cap_valid, disp_ovf_m, ovf_m;
  longint cap_val, disp_val;
  logic [15:0] word_m;
  seven_seg_serial_mux #(.BIN_W(BW), .DIGITS(ND), .CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .bin(bin), .load(load), .conv_busy(conv_busy), .overflow(overflow),
    .seg_data(seg_data), .seg_clk(seg_clk), .seg_latch(seg_latch));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t got %h exp %h", tag, $time, got, exp);
    end
  endtask
  function automatic longint p10(input int i);
    longint p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    return p;
  endfunction
  function automatic logic [7:0] seg_of(input longint v, input bit ov, input int i);
    if (ov) return 8'hBF;
`ifdef SEVSEG_BLANK_EN
    if (i > 0 && v < p10(i)) return 8'hFF;
`endif
    return SEGS[int'((v / p10(i)) % 10)];
  endfunction
  task automatic cycle();
    int p, dg, slot;
    bit hi, busy_pre;
    @(negedge clk);
    busy_pre = cap_valid && n - 1 >= cap_edge && n - 1 <= cap_edge + BW;
    p = n % FL;
    dg = (n / FL) % ND;
    slot = p / (2 * CD);
    hi = (p % (2 * CD)) >= CD;
    if (p == 0) word_m = {~(8'd1 << dg), seg_of(disp_val, disp_ovf_m, dg)};
    if (cap_valid && n == cap_edge + BW + 1) begin
      disp_val = cap_val;
      disp_ovf_m = ovf_m;
    end
    if (load && !busy_pre) begin
      cap_valid = 1;
      cap_edge = n;
      cap_val = longint'(bin);
      ovf_m = cap_val >= p10(ND);
    end
    check("seg_data", seg_data, slot < 16 ? word_m[15 - slot] : 1'b0);
    check("seg_clk", seg_clk, slot < 16 && hi);
    check("seg_latch", seg_latch, slot == 16);
    check("conv_busy", conv_busy, cap_valid && n >= cap_edge && n <= cap_edge + BW);
    check("overflow", overflow, ovf_m);
    last_dig = dg;
    last_slot = slot;
    n++;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_outs", {seg_data, seg_clk, seg_latch, conv_busy, overflow}, 5'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n = 0;
    cap_valid = 0;
    cap_edge = 0;
    disp_val = 0;
    disp_ovf_m = 0;
    ovf_m = 0;
    word_m = '0;
  endtask
  task automatic load_value(input logic [BW-1:0] v);
    load = 1'b1;
    bin = v;
    cycle();
    load = 1'b0;
    bin = BW'($urandom);
  endtask
  initial begin
    logic [BW-1:0] vals [6] = '{16'd1234, 16'd10000, 16'd7, 16'd0, 16'd9999, 16'd65535};
    rst = 1'b1;
    load = 1'b0;
    bin = '0;
    repeat (2) @(negedge clk);
    do_reset();
    repeat (300) cycle();
    foreach (vals[i]) begin
      load_value(vals[i]);
      repeat (300) cycle();
    end
    load_value(16'd4321);
    repeat (4) cycle();
    load_value(16'd8888);
    repeat (300) cycle();
    for (int i = 0; i < 2000 && !(last_dig == 2 && last_slot == 6); i++) cycle();
    check("reach_d2_bit9", last_dig == 2 && last_slot == 6, 1'b1);
    do_reset();
    repeat (300) cycle();
    for (int i = 0; i < 25; i++) begin
      load_value(i % 3 == 0 ? BW'($urandom_range(0, 99)) : BW'($urandom));
      repeat ($urandom_range(1, 120)) begin
        load = $urandom_range(0, 15) == 0;
        cycle();
      end
      load = 1'b0;
    end
    repeat (300) cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
